// File: rtl/adsr_env.sv
// adsr_env: ADSR envelope generator stepped by a divided-clock tick strobe.
// Gate edges are detected every clk against a registered copy of gate; the
// envelope level only moves on clocks where tick is high.
// Build option: define ENV_EXP_RELEASE_EN for an exponential release
// (step = max(env >> REL_SHIFT, 1)); otherwise release is linear by release_step.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | envelope parked at 0, waiting for a gate rise
// ATTACK  | ramping up by attack_step per tick until the top is reached
// DECAY   | ramping down by decay_step per tick toward sustain_level
// SUSTAIN | following sustain_level until the gate falls
// RELEASE | ramping down to 0, then back to IDLE with a done pulse
module adsr_env #(
  parameter int W         = 16,
  parameter int REL_SHIFT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         gate,
  input  logic [W-1:0] attack_step,
  input  logic [W-1:0] decay_step,
  input  logic [W-1:0] sustain_level,
  input  logic [W-1:0] release_step,
  output logic [W-1:0] env,
  output logic [2:0]   stage,
  output logic         active,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t       state_q;
  state_t       state_nxt;
  logic [W-1:0] env_nxt;
  logic         done_nxt;
  logic         gate_q;
  logic         gate_rise;
  logic         gate_fall;
  logic [W:0]   att_sum;
  logic [W:0]   dec_diff;
  logic [W-1:0] rel_step;

  assign gate_rise = gate & ~gate_q;
  assign gate_fall = ~gate & gate_q;

  // One extra bit on both sides so saturation and underflow are plain carry/borrow checks.
  assign att_sum  = {1'b0, env} + {1'b0, attack_step};
  assign dec_diff = {1'b0, env} - {1'b0, decay_step};

`ifdef ENV_EXP_RELEASE_EN
  logic [W-1:0] rel_shifted;

  // Proportional step, floored at 1 so the tail still reaches 0.
  assign rel_shifted = env >> REL_SHIFT;
  assign rel_step    = (rel_shifted == '0) ? {{(W-1){1'b0}}, 1'b1} : rel_shifted;
`else
  assign rel_step = release_step;
`endif

  assign stage = state_q;

  // State, level and strobe registers; reset acts immediately, without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      env     <= '0;
      active  <= 1'b0;
      done    <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      env     <= env_nxt;
      active  <= (state_nxt != IDLE);
      done    <= done_nxt;
      gate_q  <= gate;
    end
  end

  // Next state and level: gate edges take priority over a tick in the same clock.
  always_comb begin
    state_nxt = state_q;
    env_nxt   = env;
    done_nxt  = 1'b0;
    case (state_q)
      IDLE, ATTACK, DECAY, SUSTAIN, RELEASE: begin
        if (gate_rise) begin
          // Retrigger continues from the current level rather than restarting at 0.
          state_nxt = ATTACK;
        end else if (gate_fall && (state_q == ATTACK || state_q == DECAY ||
                                   state_q == SUSTAIN)) begin
          state_nxt = RELEASE;
        end else begin
          case (state_q)
            IDLE: begin
              env_nxt = '0;
            end
            ATTACK: begin
              if (tick && attack_step != '0) begin
                if (att_sum[W]) begin
                  env_nxt   = '1;
                  state_nxt = DECAY;
                end else begin
                  env_nxt = att_sum[W-1:0];
                end
              end
            end
            DECAY: begin
              // A zero step stalls here even if env already sits at or below sustain.
              if (tick && decay_step != '0) begin
                if (dec_diff[W] || dec_diff[W-1:0] <= sustain_level) begin
                  env_nxt   = sustain_level;
                  state_nxt = SUSTAIN;
                end else begin
                  env_nxt = dec_diff[W-1:0];
                end
              end
            end
            SUSTAIN: begin
              if (tick) begin
                env_nxt = sustain_level;
              end
            end
            RELEASE: begin
              if (tick && rel_step != '0) begin
                if (rel_step >= env) begin
                  env_nxt   = '0;
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
                end else begin
                  env_nxt = env - rel_step;
                end
              end
            end
            default: begin
              state_nxt = IDLE;
              env_nxt   = '0;
            end
          endcase
        end
      end
      default: begin
        // Encodings 5..7 are never produced; recover cleanly if one ever appears.
        state_nxt = IDLE;
        env_nxt   = '0;
      end
    endcase
  end

endmodule

// File: doc/adsr_env.md
ADSR_ENV -- requirements
Module: adsr_env

Interface
REQ-001 Parameter: W, 16, envelope/step width in bits.
REQ-002 Parameter: REL_SHIFT, 4, exponential release shift (used only when ENV_EXP_RELEASE_EN is defined).
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 tick  input  1  one-clk strobe from the clock-divider stage (1 per 10 clk); envelope advances only on tick=1.
REQ-006 gate  input  1  note on (1) / off (0), sampled every clk.
REQ-007 attack_step  input  W  increment per tick in ATTACK.
REQ-008 decay_step  input  W  decrement per tick in DECAY.
REQ-009 sustain_level  input  W  SUSTAIN target level.
REQ-010 release_step  input  W  decrement per tick in RELEASE (linear mode).
REQ-011 env  output  W  registered envelope level, unsigned.
REQ-012 stage  output  3  registered state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-013 active  output  1  registered; 1 when stage != IDLE.
REQ-014 done  output  1  registered 1-clk pulse when RELEASE reaches 0.

Function
REQ-015 Gate edges SHALL be detected against a gate register updated every clk, independent of tick.
REQ-016 Gate rise in any state SHALL enter ATTACK next clk, env unchanged (no restart from 0).
REQ-017 Gate fall in ATTACK, DECAY or SUSTAIN SHALL enter RELEASE next clk, env unchanged; gate fall in IDLE/RELEASE has no effect.
REQ-018 Gate edge and tick in the same clk: state change wins, no env step that clk.
REQ-019 ATTACK, tick: env <= env+attack_step computed in W+1 bits; sum >= 2^W -> env=all-ones, stage=DECAY.
REQ-020 DECAY, tick: env-decay_step <= sustain_level or underflow -> env=sustain_level, stage=SUSTAIN; else env <= env-decay_step.
REQ-021 SUSTAIN, tick: env <= sustain_level (tracks live changes); stays until gate fall.
REQ-022 RELEASE, tick (linear): release_step >= env -> env=0, stage=IDLE, done=1 next clk; else env <= env-release_step.
REQ-023 IDLE: env held at 0; tick ignored.
REQ-024 Zero step in ATTACK/DECAY/RELEASE SHALL hold env and stage (stall, no error).
REQ-025 env/stage/active/done update on the clk edge that samples tick; visible 1 clk after tick high; done=0 all other clks.
REQ-026 No state other than the five listed SHALL be reachable; illegal encodings SHALL return to IDLE, env=0.

Reset
REQ-027 rst=1 SHALL immediately force env=0, stage=IDLE, active=0, done=0, gate register=0, independent of clk.
REQ-028 rst mid-envelope SHALL abort it; after rst release, gate already high SHALL count as a rise (enter ATTACK next clk).

Configuration
REQ-029 Macro ENV_EXP_RELEASE_EN defined: RELEASE step = max(env>>REL_SHIFT, 1); env reaching 0 -> IDLE, done pulse; release_step ignored.
REQ-030 Macro ENV_EXP_RELEASE_EN undefined: linear release per REQ-022; REL_SHIFT unused, no shifter logic.

Verification
REQ-031 attack_step=0x4000, gate rise, 4 ticks -> env 0x4000,0x8000,0xC000,0xFFFF; stage=DECAY after 4th tick.
REQ-032 From 0xFFFF, decay_step=0x1000, sustain_level=0xE000 -> env 0xEFFF, then 0xE000, stage=SUSTAIN.
REQ-033 Linear, env=0xE000 SUSTAIN, gate fall, release_step=0x8000 -> env 0x6000, then 0x0000, stage=IDLE, done high exactly 1 clk.
REQ-034 Gate rise during RELEASE at env=0x6000 -> stage=ATTACK next clk, env=0x6000, next tick 0xA000.
REQ-035 rst pulse mid-ATTACK between clk edges -> env=0, stage=IDLE, active=0 before next clk edge.
REQ-036 ENV_EXP_RELEASE_EN, REL_SHIFT=4, env=0x0100 in RELEASE -> 0x00F0, 0x00E1; from env=0x0001 -> 0x0000, IDLE, done pulse.
